// File: rtl/nios_mtl_sysid_checker.sv
// Avalon-MM system-ID checker: reads word 0 (ID) and word 1 (timestamp)
// from a sysid slave, compares both against build-time constants and
// reports pass / timeout.  Each read has its own cycle budget.
module nios_mtl_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1461104899,
   parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [31:0] id_out,
   output logic [31:0] timestamp_out
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ID_REQ  = 3'd1,
      ID_WAIT = 3'd2,
      TS_REQ  = 3'd3,
      TS_WAIT = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t      r_state, w_state_next;
   logic [15:0] r_cnt, w_cnt_next;
   logic        r_done, w_done_next;
   logic        r_pass, w_pass_next;
   logic        r_timeout, w_timeout_next;
   logic [31:0] r_id, w_id_next;
   logic [31:0] r_ts, w_ts_next;

   logic w_read;
   logic w_accept;
   logic w_expired;

   // The read strobe and address are pure decodes of the state, so an
   // asynchronous reset drops them immediately and they cannot glitch
   // while the slave stalls.
   assign w_read    = (r_state == ID_REQ) || (r_state == TS_REQ);
   assign w_accept  = w_read && !avm_waitrequest;
   assign w_expired = (r_cnt == TIMEOUT_CYCLES);

   assign avm_read      = w_read;
   assign avm_address   = (r_state == TS_REQ);
   assign done          = r_done;
   assign pass          = r_pass;
   assign timeout       = r_timeout;
   assign id_out        = r_id;
   assign timestamp_out = r_ts;

   // State, counter and result registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_timeout <= 1'b0;
         r_id      <= '0;
         r_ts      <= '0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_done    <= w_done_next;
         r_pass    <= w_pass_next;
         r_timeout <= w_timeout_next;
         r_id      <= w_id_next;
         r_ts      <= w_ts_next;
      end
   end

   // Next-state logic: a response or acceptance always takes priority over
   // budget expiry on the same edge; otherwise an expired budget ends the
   // check with timeout set.
   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_done_next    = r_done;
      w_pass_next    = r_pass;
      w_timeout_next = r_timeout;
      w_id_next      = r_id;
      w_ts_next      = r_ts;

      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_state_next   = ID_REQ;
               w_cnt_next     = '0;
               w_done_next    = 1'b0;
               w_pass_next    = 1'b0;
               w_timeout_next = 1'b0;
            end
         end
         ID_REQ, TS_REQ: begin
            w_cnt_next = r_cnt + 16'd1;
            if (w_accept) begin
               w_state_next = (r_state == ID_REQ) ? ID_WAIT : TS_WAIT;
            end else if (w_expired) begin
               w_state_next   = DONE;
               w_done_next    = 1'b1;
               w_timeout_next = 1'b1;
               w_pass_next    = 1'b0;
            end
         end
         ID_WAIT: begin
            w_cnt_next = r_cnt + 16'd1;
            if (avm_readdatavalid) begin
               w_id_next    = avm_readdata;
               w_state_next = TS_REQ;
               w_cnt_next   = '0;
            end else if (w_expired) begin
               w_state_next   = DONE;
               w_done_next    = 1'b1;
               w_timeout_next = 1'b1;
               w_pass_next    = 1'b0;
            end
         end
         TS_WAIT: begin
            w_cnt_next = r_cnt + 16'd1;
            if (avm_readdatavalid) begin
               w_ts_next      = avm_readdata;
               w_state_next   = DONE;
               w_done_next    = 1'b1;
               w_timeout_next = 1'b0;
               w_pass_next    = (r_id == EXPECTED_ID) &&
                                (avm_readdata == EXPECTED_TIMESTAMP);
            end else if (w_expired) begin
               w_state_next   = DONE;
               w_done_next    = 1'b1;
               w_timeout_next = 1'b1;
               w_pass_next    = 1'b0;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_nios_mtl_sysid_checker.sv
// Self-checking bench for nios_mtl_sysid_checker.  A behavioural sysid
// slave serves the main instance; a second instance with a 4-cycle budget
// is driven directly to exercise expiry.  Latencies are counted with the
// edge that samples start as edge 1.
module tb_nios_mtl_sysid_checker;

   localparam logic [31:0] EXP_TS = 32'd1461104899;

   typedef struct {
      bit          pass;
      bit          tmo;
      logic [31:0] id;
      logic [31:0] ts;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // main instance signals
   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;
   logic        start   = 1'b0;
   logic        avm_address, avm_read;
   logic        avm_waitrequest   = 1'b0;
   logic [31:0] avm_readdata      = '0;
   logic        avm_readdatavalid = 1'b0;
   logic        done, pass, timeout;
   logic [31:0] id_out, timestamp_out;

   // short-budget instance signals
   logic        to_start = 1'b0;
   logic        to_address, to_read;
   logic        to_waitrequest = 1'b0;
   logic [31:0] to_readdata    = '0;
   logic        to_rdv         = 1'b0;
   logic        to_done, to_pass, to_timeout;
   logic [31:0] to_id, to_ts;

   always #5 clock = ~clock;

   nios_mtl_sysid_checker dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .done(done), .pass(pass), .timeout(timeout),
      .id_out(id_out), .timestamp_out(timestamp_out)
   );

   nios_mtl_sysid_checker #(.TIMEOUT_CYCLES(16'd4)) dut_to (
      .clock(clock), .reset_n(reset_n), .start(to_start),
      .avm_address(to_address), .avm_read(to_read),
      .avm_waitrequest(to_waitrequest), .avm_readdata(to_readdata),
      .avm_readdatavalid(to_rdv),
      .done(to_done), .pass(to_pass), .timeout(to_timeout),
      .id_out(to_id), .timestamp_out(to_ts)
   );

   // slave model controls (written by the tests only)
   logic [31:0] mem0 = 32'd0;
   logic [31:0] mem1 = EXP_TS;
   int          wait_cycles = 0;
   bit          ts_suppress = 0;
   bit          spurious    = 0;
   bit          force_rdv   = 0;
   // slave model state (written by the slave only)
   int          wcnt = 0;
   bit          acc_flag = 0;
   logic        acc_addr = 1'b0;
   bit          prev_wreq = 0;
   logic        prev_addr = 1'b0;
   int          spur_cnt = 0;
   int          stall_cnt = 0;
   int          stall_viol = 0;
   logic        acc_log[$];

   // Sysid slave: drives its inputs on the falling edge, answers one cycle
   // after acceptance, inserts wait_cycles stalls per request.
   always @(negedge clock) begin
      if (prev_wreq && (avm_read !== 1'b1 || avm_address !== prev_addr))
         stall_viol = stall_viol + 1;
      if (force_rdv) begin
         avm_readdatavalid = 1'b1;
         avm_readdata      = mem1;
         acc_flag          = 0;
      end else if (acc_flag) begin
         avm_readdatavalid = !(acc_addr && ts_suppress);
         avm_readdata      = acc_addr ? mem1 : mem0;
         acc_flag          = 0;
      end else if (spurious && spur_cnt == 0 && avm_read && avm_address) begin
         avm_readdatavalid = 1'b1;
         avm_readdata      = 32'hDEADBEEF;
         spur_cnt          = spur_cnt + 1;
      end else begin
         avm_readdatavalid = 1'b0;
      end
      if (avm_read === 1'b1) begin
         if (wcnt < wait_cycles) begin
            avm_waitrequest = 1'b1;
            wcnt            = wcnt + 1;
            stall_cnt       = stall_cnt + 1;
         end else begin
            avm_waitrequest = 1'b0;
            acc_flag        = 1;
            acc_addr        = avm_address;
            acc_log.push_back(avm_address);
            wcnt            = 0;
         end
      end else begin
         avm_waitrequest = 1'b0;
         wcnt            = 0;
      end
      prev_wreq = avm_waitrequest;
      prev_addr = avm_address;
   end

   // Pulse start for one cycle; returns #1 after the sampling edge.
   task automatic launch();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   // Wait (bounded) for done; edges counted after the sampling edge.
   task automatic wait_done(input int budget, output int edges, output bit ok);
      ok = 0;
      edges = 0;
      for (int k = 1; k <= budget; k++) begin
         @(posedge clock);
         #1;
         if (done === 1'b1) begin
            edges = k;
            ok = 1;
            break;
         end
      end
   endtask

   // Run the short-budget instance, presenting a response on edges r1 (ID)
   // and r2 (timestamp) after the sampling edge.
   task automatic run_to(input int r1, input int r2, output int edges, output bit ok);
      ok = 0;
      edges = 0;
      @(negedge clock);
      to_start = 1'b1;
      @(posedge clock);
      #1 to_start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         to_rdv      = (k == r1) || (k == r2);
         to_readdata = (k == r2) ? EXP_TS : 32'd0;
         @(posedge clock);
         #1;
         if (to_done === 1'b1) begin
            edges = k;
            ok = 1;
            break;
         end
      end
      @(negedge clock);
      to_rdv = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clock);
      #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done); end
      n_checks++; if (pass !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL reset_flags got pass=%0b tmo=%0b exp=0/0", pass, timeout); end
      n_checks++; if (avm_read !== 1'b0 || avm_address !== 1'b0) begin n_fail++; $display("FAIL reset_bus got rd=%0b addr=%0b exp=0/0", avm_read, avm_address); end
      n_checks++; if (id_out !== 32'd0 || timestamp_out !== 32'd0) begin n_fail++; $display("FAIL reset_data got id=%h ts=%h exp=0/0", id_out, timestamp_out); end
      n_checks++; if (to_done !== 1'b0 || to_read !== 1'b0) begin n_fail++; $display("FAIL reset_to got done=%0b rd=%0b exp=0/0", to_done, to_read); end
      @(negedge clock);
      reset_n = 1'b1;
      $display("reset: released");
   endtask

   task automatic test_zero_wait();
      exp_t e;
      int   base, edges;
      bit   ok;
      sb.push_back('{pass: 1, tmo: 0, id: 32'd0, ts: EXP_TS, lat: 5});
      base = acc_log.size();
      launch();
      n_checks++; if (avm_read !== 1'b1 || avm_address !== 1'b0) begin n_fail++; $display("FAIL zw_first_req got rd=%0b addr=%0b exp=1/0", avm_read, avm_address); end
      wait_done(40, edges, ok);
      e = sb.pop_front();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL zw_done got=no-done exp=done"); end
      n_checks++; if (edges + 1 !== e.lat) begin n_fail++; $display("FAIL zw_latency got=%0d exp=%0d", edges + 1, e.lat); end
      n_checks++; if (pass !== e.pass || timeout !== e.tmo) begin n_fail++; $display("FAIL zw_result got pass=%0b tmo=%0b exp=%0b/%0b", pass, timeout, e.pass, e.tmo); end
      n_checks++; if (id_out !== e.id || timestamp_out !== e.ts) begin n_fail++; $display("FAIL zw_data got id=%h ts=%h exp=%h/%h", id_out, timestamp_out, e.id, e.ts); end
      n_checks++; if (acc_log.size() - base !== 2 || acc_log[base] !== 1'b0 || acc_log[base+1] !== 1'b1) begin n_fail++; $display("FAIL zw_addr_seq got n=%0d exp=2 addrs 0,1", acc_log.size() - base); end
      n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL zw_read_idle got=%0b exp=0", avm_read); end
      $display("zero_wait: lat=%0d pass=%0b tmo=%0b id=%h ts=%h", edges + 1, pass, timeout, id_out, timestamp_out);
   endtask

   task automatic test_id_mismatch();
      exp_t e;
      int   edges;
      bit   ok;
      mem0 = 32'h00000001;
      sb.push_back('{pass: 0, tmo: 0, id: 32'h00000001, ts: EXP_TS, lat: 5});
      launch();
      n_checks++; if (done !== 1'b0 || pass !== 1'b0) begin n_fail++; $display("FAIL mm_clear got done=%0b pass=%0b exp=0/0", done, pass); end
      n_checks++; if (timestamp_out !== EXP_TS) begin n_fail++; $display("FAIL mm_retain got ts=%h exp=%h", timestamp_out, EXP_TS); end
      wait_done(40, edges, ok);
      e = sb.pop_front();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL mm_done got=no-done exp=done"); end
      n_checks++; if (pass !== e.pass || timeout !== e.tmo) begin n_fail++; $display("FAIL mm_result got pass=%0b tmo=%0b exp=%0b/%0b", pass, timeout, e.pass, e.tmo); end
      n_checks++; if (id_out !== e.id) begin n_fail++; $display("FAIL mm_id got=%h exp=%h", id_out, e.id); end
      mem0 = 32'd0;
      $display("id_mismatch: pass=%0b tmo=%0b id=%h", pass, timeout, id_out);
   endtask

   task automatic test_waitstate();
      exp_t e;
      int   edges, s0, v0;
      bit   ok;
      wait_cycles = 3;
      s0 = stall_cnt;
      v0 = stall_viol;
      sb.push_back('{pass: 1, tmo: 0, id: 32'd0, ts: EXP_TS, lat: 11});
      launch();
      wait_done(60, edges, ok);
      e = sb.pop_front();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL ws_done got=no-done exp=done"); end
      n_checks++; if (edges + 1 !== e.lat) begin n_fail++; $display("FAIL ws_latency got=%0d exp=%0d", edges + 1, e.lat); end
      n_checks++; if (pass !== e.pass || timeout !== e.tmo) begin n_fail++; $display("FAIL ws_result got pass=%0b tmo=%0b exp=%0b/%0b", pass, timeout, e.pass, e.tmo); end
      n_checks++; if (stall_cnt - s0 !== 6) begin n_fail++; $display("FAIL ws_stalls got=%0d exp=6", stall_cnt - s0); end
      n_checks++; if (stall_viol - v0 !== 0) begin n_fail++; $display("FAIL ws_stable got=%0d exp=0 violations", stall_viol - v0); end
      wait_cycles = 0;
      $display("waitstate: lat=%0d pass=%0b stalls=%0d", edges + 1, pass, stall_cnt - s0);
   endtask

   task automatic test_timeout();
      exp_t e;
      int   edges;
      bit   ok;
      sb.push_back('{pass: 0, tmo: 1, id: 32'd0, ts: 32'd0, lat: 6});
      run_to(-1, -1, edges, ok);
      e = sb.pop_front();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL to_done got=no-done exp=done"); end
      n_checks++; if (edges + 1 !== e.lat) begin n_fail++; $display("FAIL to_latency got=%0d exp=%0d", edges + 1, e.lat); end
      n_checks++; if (to_pass !== e.pass || to_timeout !== e.tmo) begin n_fail++; $display("FAIL to_result got pass=%0b tmo=%0b exp=%0b/%0b", to_pass, to_timeout, e.pass, e.tmo); end
      n_checks++; if (to_read !== 1'b0) begin n_fail++; $display("FAIL to_read_low got=%0b exp=0", to_read); end
      $display("timeout: lat=%0d pass=%0b tmo=%0b", edges + 1, to_pass, to_timeout);
   endtask

   task automatic test_expiry_race();
      exp_t e;
      int   edges;
      bit   ok;
      // responses land exactly on the edges where the 4-cycle budget expires
      sb.push_back('{pass: 1, tmo: 0, id: 32'd0, ts: EXP_TS, lat: 11});
      run_to(5, 10, edges, ok);
      e = sb.pop_front();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL race_done got=no-done exp=done"); end
      n_checks++; if (edges + 1 !== e.lat) begin n_fail++; $display("FAIL race_latency got=%0d exp=%0d", edges + 1, e.lat); end
      n_checks++; if (to_pass !== e.pass || to_timeout !== e.tmo) begin n_fail++; $display("FAIL race_result got pass=%0b tmo=%0b exp=%0b/%0b", to_pass, to_timeout, e.pass, e.tmo); end
      n_checks++; if (to_ts !== e.ts) begin n_fail++; $display("FAIL race_ts got=%h exp=%h", to_ts, e.ts); end
      $display("expiry_race: lat=%0d pass=%0b tmo=%0b", edges + 1, to_pass, to_timeout);
   endtask

   task automatic test_ignored();
      exp_t e;
      int   edges;
      bit   ok;
      wait_cycles = 2;
      spurious = 1;
      sb.push_back('{pass: 1, tmo: 0, id: 32'd0, ts: EXP_TS, lat: 9});
      launch();
      repeat (3) @(posedge clock);   // third edge accepts the ID read
      #1 start = 1'b1;                 // present start while in ID_WAIT
      @(posedge clock);
      #1 start = 1'b0;
      wait_done(40, edges, ok);
      e = sb.pop_front();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL ign_done got=no-done exp=done"); end
      n_checks++; if (edges + 5 !== e.lat) begin n_fail++; $display("FAIL ign_latency got=%0d exp=%0d", edges + 5, e.lat); end
      n_checks++; if (pass !== e.pass || timeout !== e.tmo) begin n_fail++; $display("FAIL ign_result got pass=%0b tmo=%0b exp=%0b/%0b", pass, timeout, e.pass, e.tmo); end
      n_checks++; if (timestamp_out !== e.ts) begin n_fail++; $display("FAIL ign_ts got=%h exp=%h", timestamp_out, e.ts); end
      n_checks++; if (spur_cnt !== 1) begin n_fail++; $display("FAIL ign_spurious_sent got=%0d exp=1", spur_cnt); end
      wait_cycles = 0;
      spurious = 0;
      $display("ignored: lat=%0d pass=%0b ts=%h", edges + 5, pass, timestamp_out);
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   edges;
      bit   ok;
      ts_suppress = 1;
      launch();
      repeat (3) @(posedge clock);   // third edge enters TS_WAIT
      #2 reset_n = 1'b0;
      #1;
      n_checks++; if (done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL rm_flags got done=%0b pass=%0b tmo=%0b exp=0", done, pass, timeout); end
      n_checks++; if (timestamp_out !== 32'd0 || id_out !== 32'd0) begin n_fail++; $display("FAIL rm_data got id=%h ts=%h exp=0/0", id_out, timestamp_out); end
      n_checks++; if (avm_read !== 1'b0 || avm_address !== 1'b0) begin n_fail++; $display("FAIL rm_bus got rd=%0b addr=%0b exp=0/0", avm_read, avm_address); end
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      force_rdv = 1;
      repeat (3) @(posedge clock);
      #1;
      n_checks++; if (done !== 1'b0 || timestamp_out !== 32'd0) begin n_fail++; $display("FAIL rm_stale_rsp got done=%0b ts=%h exp=0/0", done, timestamp_out); end
      @(negedge clock);
      force_rdv = 0;
      ts_suppress = 0;
      sb.push_back('{pass: 1, tmo: 0, id: 32'd0, ts: EXP_TS, lat: 5});
      launch();
      wait_done(40, edges, ok);
      e = sb.pop_front();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rm_done got=no-done exp=done"); end
      n_checks++; if (edges + 1 !== e.lat || pass !== e.pass || timeout !== e.tmo) begin n_fail++; $display("FAIL rm_rerun got lat=%0d pass=%0b tmo=%0b exp=%0d/%0b/%0b", edges + 1, pass, timeout, e.lat, e.pass, e.tmo); end
      $display("reset_mid: rerun lat=%0d pass=%0b ts=%h", edges + 1, pass, timestamp_out);
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_id_mismatch();
      test_waitstate();
      test_timeout();
      test_expiry_race();
      test_ignored();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
